// File: rtl/step_dir_decoder.sv
// Step/dir/home pin decoder with pulse filter, position and period tracking.
// Avalon-MM slave for closed-loop feedback and driver loopback checks.
module step_dir_decoder #(
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 24,
    parameter int SYNC_STAGES  = 2,
    parameter int MIN_PULSE    = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        home_in,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata
);

    localparam int HW = $clog2(MIN_PULSE + 1);
    localparam int SL = SYNC_STAGES - 1;

    typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

    state_t state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;

    logic [SL:0] step_sy, dir_sy, home_sy, primed;
    logic step_s, dir_s, home_s;
    logic step_q, home_q, armed;

    logic [POS_WIDTH-1:0] position, home_pos;
    logic [POS_WIDTH-1:0] pos_step, pos_upd;
    logic [PERIOD_WIDTH-1:0] pcnt, step_period;

    logic stale, homed, glitch;
    logic enable, invert_dir, zero_on_home;
    logic accept, glitch_set, d;
    logic step_rise, home_rise;
    logic wr_pos, wr_stat, wr_ctl;
    logic [31:0] rdata;
    logic unused_wdata;

    assign unused_wdata = ^avs_writedata;

    assign step_s = step_sy[SL];
    assign dir_s  = dir_sy[SL];
    assign home_s = home_sy[SL];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_sy <= '0;
            dir_sy  <= '0;
            home_sy <= '0;
            primed  <= '0;
            step_q  <= 1'b0;
            home_q  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            step_sy <= {step_sy[SL-1:0], step_in};
            dir_sy  <= {dir_sy[SL-1:0], dir_in};
            home_sy <= {home_sy[SL-1:0], home_in};
            primed  <= {primed[SL-1:0], 1'b1};
            step_q  <= step_s;
            home_q  <= home_s;
            // a line already high out of reset must drop before it counts
            if (primed[SL] && !step_s)
                armed <= 1'b1;
        end
    end

    assign step_rise = step_s & ~step_q & armed;
    assign home_rise = enable & home_s & ~home_q & primed[SL];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        hcnt_n     = hcnt;
        accept     = 1'b0;
        glitch_set = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            hcnt_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (step_rise) begin
                        if (MIN_PULSE == 1) begin
                            accept  = 1'b1;
                            state_n = HELD;
                        end else begin
                            state_n = QUAL;
                            hcnt_n  = HW'(1);
                        end
                    end
                end
                QUAL: begin
                    if (!step_s) begin
                        glitch_set = 1'b1;
                        state_n    = IDLE;
                    end else if (hcnt == HW'(MIN_PULSE - 1)) begin
                        accept  = 1'b1;
                        state_n = HELD;
                    end else begin
                        hcnt_n = hcnt + HW'(1);
                    end
                end
                HELD: begin
                    if (!step_s)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign wr_pos  = avs_write && (avs_address == 3'd0);
    assign wr_stat = avs_write && (avs_address == 3'd3);
    assign wr_ctl  = avs_write && (avs_address == 3'd4);

    assign d = dir_s ^ invert_dir;

    always_comb begin
        pos_step = position;
        if (accept)
            pos_step = d ? position + POS_WIDTH'(1)
                         : position - POS_WIDTH'(1);
        pos_upd = wr_pos ? avs_writedata[POS_WIDTH-1:0] : pos_step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position <= '0;
            home_pos <= '0;
            homed    <= 1'b0;
            glitch   <= 1'b0;
        end else begin
            if (home_rise && zero_on_home && !wr_pos)
                position <= '0;
            else
                position <= pos_upd;
            if (home_rise)
                home_pos <= pos_upd;
            if (home_rise)
                homed <= 1'b1;
            else if (wr_stat && avs_writedata[2])
                homed <= 1'b0;
            if (glitch_set)
                glitch <= 1'b1;
            else if (wr_stat && avs_writedata[4])
                glitch <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt         <= '0;
            step_period  <= '0;
            stale        <= 1'b0;
            enable       <= 1'b0;
            invert_dir   <= 1'b0;
            zero_on_home <= 1'b0;
        end else begin
            if (!enable) begin
                pcnt <= '0;
            end else if (accept) begin
                step_period <= pcnt;
                pcnt        <= PERIOD_WIDTH'(1);
                stale       <= 1'b0;
            end else if (pcnt == '1) begin
                step_period <= '0;
                stale       <= 1'b1;
            end else begin
                pcnt <= pcnt + PERIOD_WIDTH'(1);
            end
            // toggling enable restarts the period measurement
            if (wr_ctl && (avs_writedata[0] != enable))
                stale <= 1'b1;
            if (wr_ctl) begin
                enable       <= avs_writedata[0];
                invert_dir   <= avs_writedata[1];
                zero_on_home <= avs_writedata[2];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (avs_address)
            3'd0: rdata = 32'($signed(position));
            3'd1: rdata = 32'(step_period);
            3'd2: rdata = 32'($signed(home_pos));
            3'd3: rdata = {27'd0, glitch, stale, homed, home_s, dir_s};
            3'd4: rdata = {29'd0, zero_on_home, invert_dir, enable};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rdata;
    end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: filter, position, period, home, reset.
// Period width is reduced so saturation is reachable in a short run.
module tb_step_dir_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_in = 1'b0;
    logic        dir_in = 1'b0;
    logic        home_in = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;

    int checks = 0;
    int failures = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    step_dir_decoder #(
        .POS_WIDTH(32),
        .PERIOD_WIDTH(10),
        .SYNC_STAGES(2),
        .MIN_PULSE(25)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_in(step_in),
        .dir_in(dir_in),
        .home_in(home_in),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] dat);
        avs_address = a;
        avs_read = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        dat = avs_readdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] dat);
        avs_address = a;
        avs_writedata = dat;
        avs_write = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [2:0] a,
                        input logic [31:0] exp);
        logic [31:0] r;
        rd(a, r);
        check(tag, r, exp);
    endtask

    task automatic pulse(input int hi, input int lo);
        step_in = 1'b1;
        cyc(hi);
        step_in = 1'b0;
        cyc(lo);
    endtask

    initial begin
        cyc(3);
        check("rst_rdata", avs_readdata, 32'h0);
        reset = 1'b0;
        cyc(2);
        rchk("rst_pos", 3'd0, 32'h0);
        rchk("rst_period", 3'd1, 32'h0);
        rchk("rst_status", 3'd3, 32'h0);
        rchk("rst_ctl", 3'd4, 32'h0);
        rchk("addr5", 3'd5, 32'h0);

        dir_in = 1'b1;
        cyc(4);
        wr(3'd4, 32'h1);
        rchk("ctl_en", 3'd4, 32'h1);
        rchk("stale_on_en", 3'd3, 32'h9);

        // first pulse probes latency: 2 sync + 25 filter cycles
        step_in = 1'b1;
        cyc(26);
        rchk("lat_pre", 3'd0, 32'h0);
        rchk("lat_post", 3'd0, 32'h1);
        cyc(2);
        step_in = 1'b0;
        cyc(70);
        repeat (99) pulse(30, 70);
        rchk("pos_100", 3'd0, 32'd100);
        rchk("period_100", 3'd1, 32'd100);
        rchk("status_run", 3'd3, 32'h1);

        wr(3'd0, 32'h0);
        dir_in = 1'b0;
        cyc(4);
        repeat (5) pulse(30, 70);
        rchk("pos_neg5", 3'd0, 32'hFFFF_FFFB);
        wr(3'd4, 32'h3);
        repeat (5) pulse(30, 70);
        rchk("pos_inv", 3'd0, 32'h0);

        wr(3'd4, 32'h1);
        dir_in = 1'b1;
        cyc(4);
        pulse(10, 70);
        pulse(24, 70);
        rchk("glitch_pos", 3'd0, 32'h0);
        rchk("glitch_set", 3'd3, 32'h11);
        wr(3'd3, 32'h10);
        rchk("glitch_clr", 3'd3, 32'h1);
        pulse(25, 70);
        rchk("pulse25", 3'd0, 32'd1);
        pulse(10000, 70);
        rchk("pulse10k", 3'd0, 32'd2);

        wr(3'd0, 32'd37);
        home_in = 1'b1;
        cyc(6);
        home_in = 1'b0;
        cyc(4);
        rchk("home_pos", 3'd2, 32'd37);
        rd(3'd3, v);
        check("homed_set", v & 32'h4, 32'h4);
        wr(3'd3, 32'h4);
        rd(3'd3, v);
        check("homed_clr", v & 32'h4, 32'h0);

        // home edge lands on the same cycle as the step accept
        wr(3'd4, 32'h5);
        step_in = 1'b1;
        cyc(24);
        home_in = 1'b1;
        cyc(6);
        step_in = 1'b0;
        home_in = 1'b0;
        cyc(70);
        rchk("zero_home", 3'd0, 32'h0);

        // register write on the accept edge
        wr(3'd4, 32'h1);
        step_in = 1'b1;
        cyc(26);
        wr(3'd0, 32'd1000);
        cyc(3);
        step_in = 1'b0;
        cyc(70);
        rchk("wr_wins", 3'd0, 32'd1000);
        wr(3'd0, 32'h7FFF_FFFF);
        pulse(30, 70);
        rchk("wrap", 3'd0, 32'h8000_0000);

        cyc(1100);
        rchk("sat_period", 3'd1, 32'h0);
        rd(3'd3, v);
        check("sat_stale", v & 32'h8, 32'h8);
        pulse(30, 70);
        rd(3'd3, v);
        check("stale_clr", v & 32'h8, 32'h0);

        dir_in = 1'b0;
        step_in = 1'b1;
        cyc(10);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_rdata", avs_readdata, 32'h0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        rchk("mr_pos", 3'd0, 32'h0);
        rchk("mr_period", 3'd1, 32'h0);
        rchk("mr_home", 3'd2, 32'h0);
        rchk("mr_status", 3'd3, 32'h0);
        rchk("mr_ctl", 3'd4, 32'h0);
        wr(3'd4, 32'h1);
        cyc(100);
        rchk("mr_held", 3'd0, 32'h0);
        step_in = 1'b0;
        cyc(10);
        pulse(30, 70);
        rchk("mr_new", 3'd0, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
